tcm_sram_arbiter: RTL and testbench
===================================

// Module: tcm_sram_arbiter
// PURPOSE
//  Shares one single-port 32x1024 TCM SRAM (sram_32_1024_scl180) between the core IMEM and DMEM request ports.
//  Arbitrates per cycle, drives active-low SRAM controls, does read-modify-write for byte/half stores,
//  returns scr1-style req_ack/resp. Sits between scr1_pipe_top memory ports and the SRAM macro.
// PARAMETERS
//  TCM_BASE         32'h0000_0000  byte base address of TCM window (aligned to 4 KiB)
//  TCM_DEPTH        1024           SRAM words; window = TCM_DEPTH*4 bytes; addr0 width = $clog2(TCM_DEPTH)
//  DMEM_STARVE_MAX  4              max consecutive DMEM grants while IMEM waits (>=1)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   synchronous reset, active-high
//  imem_req        in   1   IMEM request valid
//  imem_cmd        in   1   0=read 1=write
//  imem_addr       in   32  byte address
//  imem_req_ack    out  1   request accepted this cycle
//  imem_rdata      out  32  read word, valid with imem_resp=RDY
//  imem_resp       out  2   00 IDLE, 01 RDY, 10 ER
//  dmem_req        in   1   DMEM request valid
//  dmem_cmd        in   1   0=read 1=write
//  dmem_width      in   2   00 byte, 01 half, 10 word, 11 invalid
//  dmem_addr       in   32  byte address
//  dmem_wdata      in   32  store data, right-aligned (byte [7:0], half [15:0])
//  dmem_req_ack    out  1   request accepted this cycle
//  dmem_rdata      out  32  full read word, valid with dmem_resp=RDY
//  dmem_resp       out  2   00 IDLE, 01 RDY, 10 ER
//  sram_csb0       out  1   SRAM chip select, active-low
//  sram_web0       out  1   SRAM write enable, active-low
//  sram_addr0      out  10  SRAM word address
//  sram_din0       out  32  SRAM write data
//  sram_dout0      in   32  SRAM read data, valid cycle after read select
// BEHAVIOUR
//  Reset: state=IDLE, csb0=1, web0=1, addr0=0, din0=0, req_ack=0, resp=IDLE, rdata=0, starve_cnt=0.
//  Reset mid-RMW aborts: no SRAM write issued, pending response dropped.
//  States: IDLE (accept), RMW (merge+write). IDLE pipelined: one grant per cycle, back-to-back.
//  Grant (IDLE, cycle N): req_ack=1 for the winner only, combinational from req; SRAM driven same cycle.
//  Response: cycle N+1 resp=RDY/ER, 1-cycle pulse; otherwise IDLE. rdata=sram_dout0 for reads, 0 otherwise.
//  Arbitration: DMEM wins over IMEM, except when starve_cnt==DMEM_STARVE_MAX and imem_req=1 -> IMEM wins.
//  starve_cnt: +1 on DMEM grant with imem_req=1 (saturating), cleared on IMEM grant or imem_req=0.
//  Errors (resp=ER at N+1, csb0 stays 1, no SRAM access): addr outside [TCM_BASE, TCM_BASE+4*TCM_DEPTH);
//   imem_cmd=1; dmem_width=11; misaligned (half addr[0]=1; word addr[1:0]!=0); imem addr[1:0]!=0.
//  Word read/write: csb0=0, web0=cmd?0:1, addr0=(addr-TCM_BASE)>>2, din0=wdata; resp RDY at N+1.
//  Byte/half write: cycle N SRAM read (web0=1), req_ack=1, go RMW; latch lane mask and shifted wdata
//   (shift left by 8*addr[1:0]). Cycle N+1 (RMW): write merge(sram_dout0, data, mask), web0=0, no grant
//   to either port; resp=RDY at N+2; return to IDLE at N+2 (a new grant allowed at N+2).
//  Address compare uses 32-bit unsigned arithmetic; TCM_BASE+4*TCM_DEPTH must not wrap past 2^32.
//  Both resp outputs may be nonzero in the same cycle only never: one grant per cycle, one resp per cycle.
// TESTING
//  Reset: rst=1 3 cycles, both req=1 -> csb0=1, req_ack=0, resp=00 throughout.
//  Word write 0xDEADBEEF @TCM_BASE+0x10 then read -> din0/addr0=4 web0=0; read resp=01 rdata=0xDEADBEEF.
//  Byte store 0xAA @+0x11 over 0x11223344 -> 2-cycle RMW, din0=0x1122AA44, resp=01 at N+2, req_ack low at N+1.
//  Both req held 10 cycles, DMEM_STARVE_MAX=4 -> grant pattern D,D,D,D,I,D,D,D,D,I.
//  Out-of-range addr TCM_BASE+0x1000, half at +0x3, imem write -> each resp=10 at N+1, csb0 stays 1.
//  rst asserted during RMW cycle -> web0 stays 1, no write; later read returns original word.

Source files
------------

// File: rtl/tcm_sram_arbiter_if.sv
// Core-side memory ports shared with the TCM arbiter: one IMEM (fetch) and one DMEM (load/store)
// request channel with scr1-style req/req_ack handshake and a one-cycle response.
interface tcm_sram_arbiter_if;
  logic        imem_req;
  logic        imem_cmd;
  logic [31:0] imem_addr;
  logic        imem_req_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;

  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;

  modport master (
    output imem_req, imem_cmd, imem_addr,
    input  imem_req_ack, imem_rdata, imem_resp,
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  imem_req, imem_cmd, imem_addr,
    output imem_req_ack, imem_rdata, imem_resp,
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/tcm_sram_arbiter.sv
// Shares one single-port TCM SRAM between the IMEM and DMEM ports: per-cycle arbitration with
// DMEM priority and IMEM anti-starvation, plus read-modify-write for byte/half stores.
module tcm_sram_arbiter #(
  parameter logic [31:0] TCM_BASE        = 32'h0000_0000,
  parameter int unsigned TCM_DEPTH       = 1024,
  parameter int unsigned DMEM_STARVE_MAX = 4,
  localparam int unsigned AW             = $clog2(TCM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  tcm_sram_arbiter_if.slave bus,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [AW-1:0]     sram_addr0,
  output logic [31:0]       sram_din0,
  input  logic [31:0]       sram_dout0
);

  localparam int unsigned   SW           = $clog2(DMEM_STARVE_MAX + 1);
  localparam logic [31:0]   WINDOW_BYTES = 32'(TCM_DEPTH * 4);
  localparam logic [SW-1:0] STARVE_MAX   = SW'(DMEM_STARVE_MAX);

  localparam logic [1:0] RESP_IDLE = 2'b00;
  localparam logic [1:0] RESP_RDY  = 2'b01;
  localparam logic [1:0] RESP_ER   = 2'b10;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [1:0]    imem_resp_q, imem_resp_d;
  logic [1:0]    dmem_resp_q, dmem_resp_d;
  logic          imem_rd_q, imem_rd_d;
  logic          dmem_rd_q, dmem_rd_d;
  logic [AW-1:0] rmw_addr_q, rmw_addr_d;
  logic [31:0]   rmw_data_q, rmw_data_d;
  logic [3:0]    rmw_mask_q, rmw_mask_d;

  logic          imem_err, dmem_err, dmem_sub_store;
  logic          imem_wins, dmem_wins;
  logic          imem_ack, dmem_ack;
  logic          csb, web;
  logic [AW-1:0] addr;
  logic [31:0]   din;

  // Window check is done on the offset so a non-zero base never wraps the compare.
  function automatic logic in_window(input logic [31:0] a);
    logic [31:0] off;
    off = a - TCM_BASE;
    return (a >= TCM_BASE) && (off < WINDOW_BYTES);
  endfunction

  function automatic logic [AW-1:0] word_index(input logic [31:0] a);
    logic [31:0] off;
    off = a - TCM_BASE;
    return off[AW+1:2];
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
    logic [3:0] m;
    case (width)
      W_BYTE:  m = 4'b0001 << off;
      W_HALF:  m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [1:0] off,
                                            input logic [31:0] wdata);
    logic [31:0] d;
    case (width)
      W_BYTE:  d = {24'h00_0000, wdata[7:0]};
      W_HALF:  d = {16'h0000, wdata[15:0]};
      default: d = wdata;
    endcase
    return d << {off, 3'b000};
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] mask);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return m;
  endfunction

  // Request decode and arbitration winner.
  always_comb begin
    imem_err = !in_window(bus.imem_addr) || bus.imem_cmd || (bus.imem_addr[1:0] != 2'b00);
    dmem_err = !in_window(bus.dmem_addr)
             || (bus.dmem_width == 2'b11)
             || ((bus.dmem_width == W_HALF) && bus.dmem_addr[0])
             || ((bus.dmem_width == W_WORD) && (bus.dmem_addr[1:0] != 2'b00));
    dmem_sub_store = bus.dmem_cmd && (bus.dmem_width != W_WORD);
    imem_wins = bus.imem_req && (!bus.dmem_req || (starve_q == STARVE_MAX));
    dmem_wins = bus.dmem_req && !imem_wins;
  end

  // Grant, SRAM drive and next-state computation.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    imem_resp_d = RESP_IDLE;
    dmem_resp_d = RESP_IDLE;
    imem_rd_d   = 1'b0;
    dmem_rd_d   = 1'b0;
    rmw_addr_d  = rmw_addr_q;
    rmw_data_d  = rmw_data_q;
    rmw_mask_d  = rmw_mask_q;
    imem_ack    = 1'b0;
    dmem_ack    = 1'b0;
    csb         = 1'b1;
    web         = 1'b1;
    addr        = '0;
    din         = 32'h0000_0000;

    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (imem_wins) begin
            imem_ack = 1'b1;
            starve_d = '0;
            if (imem_err) begin
              imem_resp_d = RESP_ER;
            end else begin
              csb         = 1'b0;
              addr        = word_index(bus.imem_addr);
              imem_resp_d = RESP_RDY;
              imem_rd_d   = 1'b1;
            end
          end else if (dmem_wins) begin
            dmem_ack = 1'b1;
            if (!bus.imem_req) begin
              starve_d = '0;
            end else if (starve_q != STARVE_MAX) begin
              starve_d = starve_q + SW'(1);
            end else begin
              starve_d = starve_q;
            end
            if (dmem_err) begin
              dmem_resp_d = RESP_ER;
            end else if (dmem_sub_store) begin
              // Fetch the old word now; the merged write goes out next cycle.
              csb        = 1'b0;
              addr       = word_index(bus.dmem_addr);
              rmw_addr_d = word_index(bus.dmem_addr);
              rmw_mask_d = lane_mask(bus.dmem_width, bus.dmem_addr[1:0]);
              rmw_data_d = lane_data(bus.dmem_width, bus.dmem_addr[1:0], bus.dmem_wdata);
              state_d    = ST_RMW;
            end else begin
              csb         = 1'b0;
              web         = !bus.dmem_cmd;
              addr        = word_index(bus.dmem_addr);
              din         = bus.dmem_wdata;
              dmem_resp_d = RESP_RDY;
              dmem_rd_d   = !bus.dmem_cmd;
            end
          end else begin
            starve_d = '0;
          end
        end
        ST_RMW: begin
          csb         = 1'b0;
          web         = 1'b0;
          addr        = rmw_addr_q;
          din         = merge_lanes(sram_dout0, rmw_data_q, rmw_mask_q);
          dmem_resp_d = RESP_RDY;
          state_d     = ST_IDLE;
          if (!bus.imem_req) begin
            starve_d = '0;
          end else begin
            starve_d = starve_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Controller state and registered response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      imem_resp_q <= RESP_IDLE;
      dmem_resp_q <= RESP_IDLE;
      imem_rd_q   <= 1'b0;
      dmem_rd_q   <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_data_q  <= 32'h0000_0000;
      rmw_mask_q  <= 4'b0000;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      imem_resp_q <= imem_resp_d;
      dmem_resp_q <= dmem_resp_d;
      imem_rd_q   <= imem_rd_d;
      dmem_rd_q   <= dmem_rd_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_data_q  <= rmw_data_d;
      rmw_mask_q  <= rmw_mask_d;
    end
  end

  assign bus.imem_req_ack = imem_ack;
  assign bus.dmem_req_ack = dmem_ack;
  assign bus.imem_resp    = imem_resp_q;
  assign bus.dmem_resp    = dmem_resp_q;
  // Read data comes straight off the macro in the cycle after the read select.
  assign bus.imem_rdata   = imem_rd_q ? sram_dout0 : 32'h0000_0000;
  assign bus.dmem_rdata   = dmem_rd_q ? sram_dout0 : 32'h0000_0000;

  assign sram_csb0  = csb;
  assign sram_web0  = web;
  assign sram_addr0 = addr;
  assign sram_din0  = din;

endmodule

// File: tb/tb_tcm_sram_arbiter.sv
// Directed bench for tcm_sram_arbiter: expected responses are queued when a request is granted
// and compared when the arbiter responds; an SRAM model stands in for the macro.
module tb_tcm_sram_arbiter;

  localparam logic [1:0] RDY = 2'b01;
  localparam logic [1:0] ER  = 2'b10;

  typedef struct {
    int          due;
    bit          dm;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_csb0, sram_web0;
  logic [9:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;
  logic [31:0] sram_mem [0:1023];

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [31:0] ref_w10;
  logic [9:0]  starve_pat;

  tcm_sram_arbiter_if bus();

  tcm_sram_arbiter #(
    .TCM_BASE       (32'h0000_0000),
    .TCM_DEPTH      (1024),
    .DMEM_STARVE_MAX(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_csb0 (sram_csb0),
    .sram_web0 (sram_web0),
    .sram_addr0(sram_addr0),
    .sram_din0 (sram_din0),
    .sram_dout0(sram_dout0)
  );

  always #5 clk = ~clk;

  // Single-port SRAM macro: write on web0=0, registered read data otherwise.
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) sram_mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= sram_mem[sram_addr0];
    end
  end

  function automatic logic [31:0] store_merge(input logic [31:0] old_w, input logic [1:0] width,
                                              input logic [1:0] off, input logic [31:0] data);
    logic [31:0] keep;
    logic [31:0] val;
    if (width == 2'b00) begin
      keep = 32'h0000_00FF << {off, 3'b000};
      val  = {24'h0, data[7:0]} << {off, 3'b000};
    end else if (width == 2'b01) begin
      keep = 32'h0000_FFFF << {off, 3'b000};
      val  = {16'h0, data[15:0]} << {off, 3'b000};
    end else begin
      keep = 32'hFFFF_FFFF;
      val  = data;
    end
    return (old_w & ~keep) | (val & keep);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit dm, input logic [1:0] resp, input logic [31:0] rdata, input int lat);
    exp_t e;
    e.due = cyc + lat; e.dm = dm; e.resp = resp; e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  task automatic sb_sample();
    exp_t e;
    if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      if (e.dm) begin
        check("dmem_resp", 32'(bus.dmem_resp), 32'(e.resp));
        check("dmem_rdata", bus.dmem_rdata, e.rdata);
        check("imem_resp_quiet", 32'(bus.imem_resp), 32'h0);
      end else begin
        check("imem_resp", 32'(bus.imem_resp), 32'(e.resp));
        check("imem_rdata", bus.imem_rdata, e.rdata);
        check("dmem_resp_quiet", 32'(bus.dmem_resp), 32'h0);
      end
    end else begin
      check("resp_idle", 32'({bus.imem_resp, bus.dmem_resp}), 32'h0);
    end
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic cyc_end();
    sb_sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_bus();
    bus.imem_req = 1'b0; bus.imem_cmd = 1'b0; bus.imem_addr = 32'h0;
    bus.dmem_req = 1'b0; bus.dmem_cmd = 1'b0; bus.dmem_width = 2'b10;
    bus.dmem_addr = 32'h0; bus.dmem_wdata = 32'h0;
  endtask

  task automatic imem_op(input logic cmd, input logic [31:0] a);
    bus.imem_req = 1'b1; bus.imem_cmd = cmd; bus.imem_addr = a;
  endtask

  task automatic dmem_op(input logic cmd, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    bus.dmem_req = 1'b1; bus.dmem_cmd = cmd; bus.dmem_width = w;
    bus.dmem_addr = a; bus.dmem_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    idle_bus();
    imem_op(1'b0, 32'h0);
    dmem_op(1'b0, 2'b10, 32'h0, 32'h0);
    @(posedge clk);
    #1;

    // Reset held with both ports requesting.
    for (int i = 0; i < 3; i++) begin
      mid();
      check("rst_csb_ack", 32'({sram_csb0, bus.imem_req_ack, bus.dmem_req_ack}), 32'h4);
      check("rst_web_addr_din", 32'({sram_web0, sram_addr0}) ^ sram_din0, 32'h400);
      check("rst_rdata", bus.imem_rdata | bus.dmem_rdata, 32'h0);
      cyc_end();
    end
    rst = 1'b0;
    idle_bus();
    mid();
    cyc_end();

    // Word write then back-to-back word read.
    dmem_op(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF);
    mid();
    check("ww_ack", 32'({bus.imem_req_ack, bus.dmem_req_ack}), 32'h1);
    check("ww_ctl", 32'({sram_csb0, sram_web0}), 32'h0);
    check("ww_addr0", 32'(sram_addr0), 32'h4);
    check("ww_din0", sram_din0, 32'hDEAD_BEEF);
    ref_w10 = 32'hDEAD_BEEF;
    push(1'b1, RDY, 32'h0, 1);
    cyc_end();
    dmem_op(1'b0, 2'b10, 32'h10, 32'h0);
    mid();
    check("wr_ctl", 32'({sram_csb0, sram_web0}), 32'h1);
    check("wr_addr0", 32'(sram_addr0), 32'h4);
    push(1'b1, RDY, ref_w10, 1);
    cyc_end();

    // Byte store over 0x11223344: two-cycle read-modify-write.
    dmem_op(1'b1, 2'b10, 32'h10, 32'h1122_3344);
    mid();
    ref_w10 = 32'h1122_3344;
    push(1'b1, RDY, 32'h0, 1);
    cyc_end();
    dmem_op(1'b1, 2'b00, 32'h11, 32'h0000_00AA);
    mid();
    check("rmw_rd_ack", 32'(bus.dmem_req_ack), 32'h1);
    check("rmw_rd_ctl", 32'({sram_csb0, sram_web0}), 32'h1);
    check("rmw_rd_addr0", 32'(sram_addr0), 32'h4);
    ref_w10 = store_merge(ref_w10, 2'b00, 2'b01, 32'h0000_00AA);
    push(1'b1, RDY, 32'h0, 2);
    cyc_end();
    dmem_op(1'b0, 2'b10, 32'h10, 32'h0);
    imem_op(1'b0, 32'h20);
    mid();
    check("rmw_no_ack", 32'({bus.imem_req_ack, bus.dmem_req_ack}), 32'h0);
    check("rmw_wr_ctl", 32'({sram_csb0, sram_web0}), 32'h0);
    check("rmw_din0", sram_din0, 32'h1122_AA44);
    check("rmw_wr_addr0", 32'(sram_addr0), 32'h4);
    cyc_end();
    bus.imem_req = 1'b0;
    mid();
    check("post_rmw_ack", 32'(bus.dmem_req_ack), 32'h1);
    push(1'b1, RDY, 32'h1122_AA44, 1);
    cyc_end();

    // Half store into the upper lanes, then read back.
    dmem_op(1'b1, 2'b01, 32'h12, 32'h1234_BEEF);
    mid();
    ref_w10 = store_merge(ref_w10, 2'b01, 2'b10, 32'h1234_BEEF);
    push(1'b1, RDY, 32'h0, 2);
    cyc_end();
    idle_bus();
    mid();
    check("half_din0", sram_din0, ref_w10);
    cyc_end();
    dmem_op(1'b0, 2'b10, 32'h10, 32'h0);
    mid();
    push(1'b1, RDY, ref_w10, 1);
    cyc_end();

    // Both ports held: DMEM priority with IMEM let through every fifth cycle.
    starve_pat = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      imem_op(1'b0, 32'h10);
      dmem_op(1'b0, 2'b10, 32'h10, 32'h0);
      mid();
      if (starve_pat[i]) begin
        check("grant_imem", 32'({bus.imem_req_ack, bus.dmem_req_ack}), 32'h2);
        push(1'b0, RDY, ref_w10, 1);
      end else begin
        check("grant_dmem", 32'({bus.imem_req_ack, bus.dmem_req_ack}), 32'h1);
        push(1'b1, RDY, ref_w10, 1);
      end
      cyc_end();
    end
    idle_bus();

    // Error cases: no SRAM access, ER one cycle later.
    dmem_op(1'b0, 2'b10, 32'h1000, 32'h0);
    mid();
    check("err_oor", 32'({sram_csb0, bus.dmem_req_ack}), 32'h3);
    push(1'b1, ER, 32'h0, 1);
    cyc_end();
    dmem_op(1'b0, 2'b01, 32'h3, 32'h0);
    mid();
    check("err_half_misalign", 32'({sram_csb0, bus.dmem_req_ack}), 32'h3);
    push(1'b1, ER, 32'h0, 1);
    cyc_end();
    dmem_op(1'b1, 2'b11, 32'h10, 32'h0);
    mid();
    check("err_width", 32'({sram_csb0, bus.dmem_req_ack}), 32'h3);
    push(1'b1, ER, 32'h0, 1);
    cyc_end();
    idle_bus();
    imem_op(1'b1, 32'h20);
    mid();
    check("err_imem_write", 32'({sram_csb0, bus.imem_req_ack}), 32'h3);
    push(1'b0, ER, 32'h0, 1);
    cyc_end();
    imem_op(1'b0, 32'h12);
    mid();
    check("err_imem_misalign", 32'({sram_csb0, bus.imem_req_ack}), 32'h3);
    push(1'b0, ER, 32'h0, 1);
    cyc_end();
    idle_bus();

    // Reset during the RMW write cycle drops the store and its response.
    dmem_op(1'b1, 2'b00, 32'h13, 32'h0000_0077);
    mid();
    check("abort_ack", 32'(bus.dmem_req_ack), 32'h1);
    cyc_end();
    idle_bus();
    rst = 1'b1;
    mid();
    check("abort_no_write", 32'({sram_csb0, sram_web0}), 32'h3);
    cyc_end();
    rst = 1'b0;
    mid();
    cyc_end();
    dmem_op(1'b0, 2'b10, 32'h10, 32'h0);
    mid();
    push(1'b1, RDY, ref_w10, 1);
    cyc_end();
    idle_bus();
    mid();
    cyc_end();
    mid();
    cyc_end();
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
